// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage.
// Contents: control-bundle bit indices, ALU op codes, the multiply/divide FSM
// state enum, and funct3 encodings for branches and the RV32M operations.
package ex_pkg;

  // Control bundle layout (id_ex_ctrl / ex_mem_ctrl)
  localparam int CTRL_ALU_SRC = 0;   // 1: operand b comes from the immediate
  localparam int CTRL_ALU_OP  = 1;   // ALU op field, ALU_OP_W bits wide
  localparam int ALU_OP_W     = 4;
  localparam int CTRL_BRANCH  = 5;
  localparam int CTRL_JUMP    = 6;
  localparam int CTRL_JALR    = 7;   // target taken from rs1 + imm
  localparam int CTRL_MD_EN   = 8;   // multiply/divide op, funct3 selects which
  localparam int CTRL_MEM_RD  = 9;
  localparam int CTRL_MEM_WR  = 10;
  localparam int CTRL_REG_WR  = 11;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;

  typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV, MD_DONE} md_state_e;

  // Branch conditions
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // RV32M operations
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/alu.sv
// Single-cycle integer ALU.
// Ports: op (alu_op_e), a/b operands (XLEN), y result (XLEN).
// Shift amount is b[log2(XLEN)-1:0]; all arithmetic wraps modulo 2^XLEN.
module alu
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);
  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:    y = a + b;
      ALU_SUB:    y = a - b;
      ALU_SLL:    y = a << shamt;
      ALU_SLT:    y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:   y = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:    y = a ^ b;
      ALU_SRL:    y = a >> shamt;
      ALU_SRA:    y = $signed(a) >>> shamt;
      ALU_OR:     y = a | b;
      ALU_AND:    y = a & b;
      ALU_PASS_B: y = b;
      default:    y = '0;
    endcase
  end
endmodule

// File: rtl/md_unit.sv
// RV32M multiply/divide unit.
// Ports: clk, reset (async, active-high); start (accept op, latch operands),
// abort (drop the op in flight), hold (stay in DONE while downstream stalls);
// funct3 selects the M-op; op_a/op_b operands; active (MUL or DIV in
// progress), done (result valid this cycle); result.
// Multiplies use a MUL_LAT-deep product pipeline; divides use XLEN
// iterations of restoring division on operand magnitudes, signs fixed up at
// the end.
module md_unit
  import ex_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic            hold,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            active,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT > 1 ? MUL_LAT - 2 : 0);
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);

  md_state_e       state, state_n;
  logic [CW-1:0]   cnt;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] quo, rem, dvsr;
  logic            neg_q, neg_r, div0;

  // Operand magnitudes for the divider (signed ops only)
  logic            div_signed;
  logic [XLEN-1:0] a_mag, b_mag;
  assign div_signed = ~funct3[0];
  assign a_mag = (div_signed && op_a[XLEN-1]) ? -op_a : op_a;
  assign b_mag = (div_signed && op_b[XLEN-1]) ? -op_b : op_b;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  logic [XLEN:0] rem_sh, diff;
  assign rem_sh = {rem, quo[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dvsr};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= MD_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      MD_IDLE: if (start) state_n = funct3[2] ? MD_DIV : (MUL_LAT == 1 ? MD_DONE : MD_MUL);
      MD_MUL:  if (abort) state_n = MD_IDLE; else if (cnt == MUL_LAST) state_n = MD_DONE;
      MD_DIV:  if (abort) state_n = MD_IDLE; else if (cnt == DIV_LAST) state_n = MD_DONE;
      MD_DONE: if (abort || !hold) state_n = MD_IDLE;
      default: state_n = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      f3_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      quo   <= '0;
      rem   <= '0;
      dvsr  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0  <= 1'b0;
    end else if (state == MD_IDLE && start) begin
      cnt   <= '0;
      f3_q  <= funct3;
      a_q   <= op_a;
      b_q   <= op_b;
      quo   <= a_mag;
      rem   <= '0;
      dvsr  <= b_mag;
      neg_q <= div_signed & (op_a[XLEN-1] ^ op_b[XLEN-1]);
      neg_r <= div_signed & op_a[XLEN-1];
      div0  <= (op_b == '0);
    end else if (state == MD_MUL) begin
      cnt <= cnt + CW'(1);
    end else if (state == MD_DIV) begin
      cnt <= cnt + CW'(1);
      quo <= {quo[XLEN-2:0], ~diff[XLEN]};
      rem <= diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    end
  end

  // Multiplier: extend each operand to 2*XLEN according to its signedness;
  // the low 2*XLEN bits of the wrapped product are the exact result.
  logic            sa, sb;
  logic [2*XLEN-1:0] a_w, b_w, prod_c, prod_o;
  assign sa = (f3_q == F3_MULH) || (f3_q == F3_MULHSU);
  assign sb = (f3_q == F3_MULH);
  assign a_w = sa ? {{XLEN{a_q[XLEN-1]}}, a_q} : {{XLEN{1'b0}}, a_q};
  assign b_w = sb ? {{XLEN{b_q[XLEN-1]}}, b_q} : {{XLEN{1'b0}}, b_q};
  assign prod_c = a_w * b_w;

  // Product pipeline: MUL_LAT-1 register stages so prod_o is valid in DONE
  if (MUL_LAT == 1) begin : g_mul_comb
    assign prod_o = prod_c;
  end else begin : g_mul_pipe
    logic [MUL_LAT-2:0][2*XLEN-1:0] mpipe;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) mpipe <= '0;
      else begin
        mpipe[0] <= prod_c;
        for (int i = 1; i < MUL_LAT - 1; i++) mpipe[i] <= mpipe[i-1];
      end
    end
    assign prod_o = mpipe[MUL_LAT-2];
  end

  // Sign fix-up. Divide by zero yields all-ones quotient and the dividend as
  // remainder (rem already holds |a|, neg_r restores its sign). MIN / -1
  // needs no special case: |MIN| / 1 negated wraps back to MIN, remainder 0.
  logic [XLEN-1:0] q_out, r_out;
  assign q_out = div0 ? '1 : (neg_q ? -quo : quo);
  assign r_out = neg_r ? -rem : rem;

  always_comb begin
    result = '0;
    if (f3_q[2])                result = f3_q[1] ? r_out : q_out;
    else if (f3_q == F3_MUL)    result = prod_o[XLEN-1:0];
    else                        result = prod_o[2*XLEN-1:XLEN];
  end

  assign active = (state == MD_MUL) || (state == MD_DIV);
  assign done   = (state == MD_DONE);
endmodule

// File: rtl/ex_stage_md.sv
// Execute stage with RV32M support.
// Ports: clk, reset (async, active-high); id_ex_* instruction from ID/EX;
// forward_a/b + fwd_mem_data/fwd_wb_data operand forwarding; flush kills the
// instruction in EX; mem_stall holds EX/MEM. Outputs: ex_busy to the hazard
// unit, ex_mem_* EX/MEM register, ex_result_fwd combinational result,
// branch_taken/branch_target redirect to IF.
// MD ops hold ID/EX via ex_busy from the accept cycle until DONE, so the
// instruction's pc/rd/ctrl are still on id_ex_* when the result is written.
module ex_stage_md
  import ex_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int CTRL_W  = 16,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   id_ex_pc,
  input  logic [2:0]        id_ex_funct3,
  input  logic [XLEN-1:0]   id_ex_rs1_data,
  input  logic [XLEN-1:0]   id_ex_rs2_data,
  input  logic [XLEN-1:0]   id_ex_imm,
  input  logic [4:0]        id_ex_rd_addr,
  input  logic [CTRL_W-1:0] id_ex_ctrl,
  input  logic              id_ex_valid,
  input  logic [1:0]        forward_a,
  input  logic [1:0]        forward_b,
  input  logic [XLEN-1:0]   fwd_mem_data,
  input  logic [XLEN-1:0]   fwd_wb_data,
  input  logic              flush,
  input  logic              mem_stall,
  output logic              ex_busy,
  output logic [XLEN-1:0]   ex_mem_pc,
  output logic [XLEN-1:0]   ex_mem_result,
  output logic [XLEN-1:0]   ex_mem_rs2_data,
  output logic [4:0]        ex_mem_rd_addr,
  output logic [CTRL_W-1:0] ex_mem_ctrl,
  output logic              ex_mem_valid,
  output logic [XLEN-1:0]   ex_result_fwd,
  output logic              branch_taken,
  output logic [XLEN-1:0]   branch_target
);
  logic [XLEN-1:0] fwd_rs1, fwd_rs2, alu_b, alu_y, md_y, link;

  always_comb begin
    case (forward_a)
      2'b01:   fwd_rs1 = fwd_wb_data;
      2'b10:   fwd_rs1 = fwd_mem_data;
      default: fwd_rs1 = id_ex_rs1_data;
    endcase
    case (forward_b)
      2'b01:   fwd_rs2 = fwd_wb_data;
      2'b10:   fwd_rs2 = fwd_mem_data;
      default: fwd_rs2 = id_ex_rs2_data;
    endcase
  end

  assign alu_b = id_ex_ctrl[CTRL_ALU_SRC] ? id_ex_imm : fwd_rs2;

  alu #(.XLEN(XLEN)) u_alu (
    .op (alu_op_e'(id_ex_ctrl[CTRL_ALU_OP +: ALU_OP_W])),
    .a  (fwd_rs1),
    .b  (alu_b),
    .y  (alu_y)
  );

  // Branch / jump resolution
  logic is_jalr, is_jump, is_br, cond;
  assign is_jalr = id_ex_ctrl[CTRL_JALR];
  assign is_jump = id_ex_ctrl[CTRL_JUMP] | is_jalr;
  assign is_br   = id_ex_ctrl[CTRL_BRANCH];

  always_comb begin
    cond = 1'b0;
    case (id_ex_funct3)
      F3_BEQ:  cond = (fwd_rs1 == fwd_rs2);
      F3_BNE:  cond = (fwd_rs1 != fwd_rs2);
      F3_BLT:  cond = ($signed(fwd_rs1) <  $signed(fwd_rs2));
      F3_BGE:  cond = ($signed(fwd_rs1) >= $signed(fwd_rs2));
      F3_BLTU: cond = (fwd_rs1 <  fwd_rs2);
      F3_BGEU: cond = (fwd_rs1 >= fwd_rs2);
      default: cond = 1'b0;
    endcase
  end

  logic [XLEN-1:0] jalr_sum;
  assign jalr_sum      = fwd_rs1 + id_ex_imm;
  assign branch_target = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : id_ex_pc + id_ex_imm;
  assign link          = id_ex_pc + XLEN'(4);

  // Multiply/divide
  logic md_start, md_active, md_done;
  assign md_start = ~reset & id_ex_valid & id_ex_ctrl[CTRL_MD_EN] & ~flush
                  & ~md_active & ~md_done;

  md_unit #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) u_md (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .abort  (flush),
    .hold   (mem_stall),
    .funct3 (id_ex_funct3),
    .op_a   (fwd_rs1),
    .op_b   (fwd_rs2),
    .active (md_active),
    .done   (md_done),
    .result (md_y)
  );

  // In DONE busy drops unless MEM is stalled; in IDLE busy follows mem_stall
  // or an op being accepted this cycle.
  assign ex_busy      = ~reset & (md_active | md_start | mem_stall);
  assign branch_taken = id_ex_valid & ~flush & ~ex_busy & (is_jump | (is_br & cond));

  assign ex_result_fwd = md_done ? md_y : (is_jump ? link : alu_y);

  // Accept cycle and MUL/DIV cycles write bubbles; DONE writes the result
  logic valid_d;
  assign valid_d = md_done ? ~flush
                 : (md_active | md_start) ? 1'b0
                 : id_ex_valid & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_mem_pc       <= '0;
      ex_mem_result   <= '0;
      ex_mem_rs2_data <= '0;
      ex_mem_rd_addr  <= '0;
      ex_mem_ctrl     <= '0;
      ex_mem_valid    <= 1'b0;
    end else if (!mem_stall) begin
      ex_mem_pc       <= id_ex_pc;
      ex_mem_result   <= ex_result_fwd;
      ex_mem_rs2_data <= fwd_rs2;
      ex_mem_rd_addr  <= id_ex_rd_addr;
      ex_mem_ctrl     <= id_ex_ctrl;
      ex_mem_valid    <= valid_d;
    end
  end
endmodule

// File: tb/tb_ex_stage_md.sv
module tb_ex_stage_md;
  import ex_pkg::*;

  logic        clk = 0, reset = 1;
  logic [31:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic [2:0]  id_ex_funct3;
  logic [4:0]  id_ex_rd_addr;
  logic [15:0] id_ex_ctrl;
  logic        id_ex_valid, flush, mem_stall;
  logic [1:0]  forward_a, forward_b;
  logic [31:0] fwd_mem_data, fwd_wb_data;
  logic        ex_busy, ex_mem_valid, branch_taken;
  logic [31:0] ex_mem_pc, ex_mem_result, ex_mem_rs2_data, ex_result_fwd, branch_target;
  logic [4:0]  ex_mem_rd_addr;
  logic [15:0] ex_mem_ctrl;

  int checks = 0, failures = 0;

  ex_stage_md #(.XLEN(32), .CTRL_W(16), .MUL_LAT(2)) dut (
    .clk(clk), .reset(reset), .id_ex_pc(id_ex_pc), .id_ex_funct3(id_ex_funct3),
    .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data), .id_ex_imm(id_ex_imm),
    .id_ex_rd_addr(id_ex_rd_addr), .id_ex_ctrl(id_ex_ctrl), .id_ex_valid(id_ex_valid),
    .forward_a(forward_a), .forward_b(forward_b), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_data(fwd_wb_data), .flush(flush), .mem_stall(mem_stall), .ex_busy(ex_busy),
    .ex_mem_pc(ex_mem_pc), .ex_mem_result(ex_mem_result), .ex_mem_rs2_data(ex_mem_rs2_data),
    .ex_mem_rd_addr(ex_mem_rd_addr), .ex_mem_ctrl(ex_mem_ctrl), .ex_mem_valid(ex_mem_valid),
    .ex_result_fwd(ex_result_fwd), .branch_taken(branch_taken), .branch_target(branch_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [15:0] ctrl;
    logic [2:0]  f3;
    logic [31:0] pc, rs1, rs2, imm;
    logic [1:0]  fa, fb;
    logic [31:0] memd, wbd, res;
    logic        tk;
    logic [31:0] tgt;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] mk(alu_op_e op, bit src, bit br, bit jmp, bit jalr, bit md);
    logic [15:0] c;
    c = '0;
    c[CTRL_ALU_OP +: ALU_OP_W] = op;
    c[CTRL_ALU_SRC] = src;
    c[CTRL_BRANCH]  = br;
    c[CTRL_JUMP]    = jmp;
    c[CTRL_JALR]    = jalr;
    c[CTRL_MD_EN]   = md;
    c[CTRL_REG_WR]  = ~br;
    return c;
  endfunction

  task automatic addv(input string nm, input logic [15:0] c, input logic [2:0] f3,
                      input logic [31:0] pc, rs1, rs2, imm, input logic [1:0] fa, fb,
                      input logic [31:0] md_, wd, res, input logic tk, input logic [31:0] tgt);
    vec_t v;
    v.nm = nm; v.ctrl = c; v.f3 = f3; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.fa = fa; v.fb = fb; v.memd = md_; v.wbd = wd; v.res = res; v.tk = tk; v.tgt = tgt;
    vt.push_back(v);
  endtask

  task automatic apply(input vec_t v, input logic [4:0] rd);
    id_ex_valid = 1; id_ex_ctrl = v.ctrl; id_ex_funct3 = v.f3; id_ex_pc = v.pc;
    id_ex_rs1_data = v.rs1; id_ex_rs2_data = v.rs2; id_ex_imm = v.imm; id_ex_rd_addr = rd;
    forward_a = v.fa; forward_b = v.fb; fwd_mem_data = v.memd; fwd_wb_data = v.wbd;
  endtask

  task automatic md_inputs(input logic [2:0] f3, input logic [31:0] a, b);
    id_ex_valid = 1; id_ex_ctrl = mk(ALU_ADD, 0, 0, 0, 0, 1); id_ex_funct3 = f3;
    id_ex_rs1_data = a; id_ex_rs2_data = b; id_ex_imm = 0; forward_a = 0; forward_b = 0;
  endtask

  // Start an M-op, count busy cycles, then expect exactly one valid result beat
  task automatic run_md(input string nm, input logic [2:0] f3, input logic [31:0] a, b, exp,
                        input int lat);
    int  n;
    bit  bub;
    n = 0; bub = 0;
    md_inputs(f3, a, b);
    #1;
    while (ex_busy && n < 100) begin
      @(posedge clk); #1; n++;
      if (ex_mem_valid) bub = 1;
    end
    chk({nm, "_lat"}, n, lat);
    chk({nm, "_bubble"}, 32'(bub), 0);
    @(posedge clk); #1;
    id_ex_valid = 0;
    chk({nm, "_valid"}, 32'(ex_mem_valid), 1);
    chk({nm, "_res"}, ex_mem_result, exp);
    @(posedge clk); #1;
    chk({nm, "_onebeat"}, 32'(ex_mem_valid), 0);
  endtask

  initial begin
    bit seen;
    id_ex_valid = 0; id_ex_ctrl = 0; id_ex_funct3 = 0; id_ex_pc = 0; id_ex_rs1_data = 0;
    id_ex_rs2_data = 0; id_ex_imm = 0; id_ex_rd_addr = 0; forward_a = 0; forward_b = 0;
    fwd_mem_data = 0; fwd_wb_data = 0; flush = 0; mem_stall = 0;

    // name                ctrl                           f3      pc        rs1          rs2          imm          fa fb memd wbd   res          tk tgt
    addv("add_fwdmem", mk(ALU_ADD,0,0,0,0,0),  3'b000, 32'h0,   32'h99,      32'h7,       32'h0,       2, 0, 5, 0,    32'd12,      0, 0);
    addv("sub",        mk(ALU_SUB,0,0,0,0,0),  3'b000, 32'h0,   32'h3,       32'h5,       32'h0,       0, 0, 0, 0,    32'hFFFFFFFE,0, 0);
    addv("addi_wrap",  mk(ALU_ADD,1,0,0,0,0),  3'b000, 32'h0,   32'h10,      32'h1234,    32'hFFFFFFF0,0, 0, 0, 0,    32'h0,       0, 0);
    addv("sll_mask",   mk(ALU_SLL,0,0,0,0,0),  3'b000, 32'h0,   32'h1,       32'h21,      32'h0,       0, 0, 0, 0,    32'h2,       0, 0);
    addv("sra",        mk(ALU_SRA,0,0,0,0,0),  3'b000, 32'h0,   32'h80000000,32'h4,       32'h0,       0, 0, 0, 0,    32'hF8000000,0, 0);
    addv("srl",        mk(ALU_SRL,0,0,0,0,0),  3'b000, 32'h0,   32'h80000000,32'h4,       32'h0,       0, 0, 0, 0,    32'h08000000,0, 0);
    addv("slt",        mk(ALU_SLT,0,0,0,0,0),  3'b000, 32'h0,   32'hFFFFFFFF,32'h1,       32'h0,       0, 0, 0, 0,    32'h1,       0, 0);
    addv("sltu",       mk(ALU_SLTU,0,0,0,0,0), 3'b000, 32'h0,   32'hFFFFFFFF,32'h1,       32'h0,       0, 0, 0, 0,    32'h0,       0, 0);
    addv("xor_fwdwb",  mk(ALU_XOR,0,0,0,0,0),  3'b000, 32'h0,   32'h0F,      32'h55,      32'h0,       0, 1, 0, 32'hFF,32'hF0,     0, 0);
    addv("or",         mk(ALU_OR,0,0,0,0,0),   3'b000, 32'h0,   32'hF0,      32'h0F,      32'h0,       0, 0, 0, 0,    32'hFF,      0, 0);
    addv("and",        mk(ALU_AND,0,0,0,0,0),  3'b000, 32'h0,   32'hFF,      32'h0F,      32'h0,       0, 0, 0, 0,    32'h0F,      0, 0);
    addv("blt_taken",  mk(ALU_ADD,0,1,0,0,0),  3'b100, 32'h100, 32'hFFFFFFFF,32'h1,       32'h20,      0, 0, 0, 0,    32'h0,       1, 32'h120);
    addv("beq_nt",     mk(ALU_ADD,0,1,0,0,0),  3'b000, 32'h100, 32'h5,       32'h6,       32'h20,      0, 0, 0, 0,    32'hB,       0, 0);
    addv("bgeu_nt",    mk(ALU_ADD,0,1,0,0,0),  3'b111, 32'h100, 32'h1,       32'hFFFFFFFF,32'h20,      0, 0, 0, 0,    32'h0,       0, 0);
    addv("bne_fwd3",   mk(ALU_ADD,0,1,0,0,0),  3'b001, 32'h200, 32'h2,       32'h3,       32'h10,      3, 0, 2, 2,    32'h5,       1, 32'h210);
    addv("bge_taken",  mk(ALU_ADD,0,1,0,0,0),  3'b101, 32'h40,  32'h5,       32'hFFFFFFFB,32'hFFFFFFF8,0, 0, 0, 0,    32'h0,       1, 32'h38);
    addv("br_f3_010",  mk(ALU_ADD,0,1,0,0,0),  3'b010, 32'h40,  32'h1,       32'h1,       32'h8,       0, 0, 0, 0,    32'h2,       0, 0);
    addv("bltu_taken", mk(ALU_ADD,0,1,0,0,0),  3'b110, 32'h0,   32'h1,       32'hFFFFFFFF,32'h8,       0, 0, 0, 0,    32'h0,       1, 32'h8);
    addv("jalr",       mk(ALU_ADD,1,0,1,1,0),  3'b000, 32'h300, 32'h203,     32'h0,       32'h0,       0, 0, 0, 0,    32'h304,     1, 32'h202);
    addv("jal",        mk(ALU_ADD,1,0,1,0,0),  3'b000, 32'h400, 32'h0,       32'h0,       32'hFFFFFFF0,0, 0, 0, 0,    32'h404,     1, 32'h3F0);
    addv("lui_passb",  mk(ALU_PASS_B,1,0,0,0,0),3'b000,32'h0,   32'h77,      32'h0,       32'hABCDE000,0, 0, 0, 0,    32'hABCDE000,0, 0);

    // Reset state
    #1;
    chk("rst_valid", 32'(ex_mem_valid), 0);
    chk("rst_result", ex_mem_result, 0);
    chk("rst_busy", 32'(ex_busy), 0);
    @(posedge clk); #1; reset = 0;

    foreach (vt[i]) begin
      apply(vt[i], 5'(i + 1));
      #1;
      chk({vt[i].nm, "_taken"}, 32'(branch_taken), 32'(vt[i].tk));
      if (vt[i].tk) chk({vt[i].nm, "_target"}, branch_target, vt[i].tgt);
      chk({vt[i].nm, "_fwd"}, ex_result_fwd, vt[i].res);
      @(posedge clk); #1;
      chk({vt[i].nm, "_res"}, ex_mem_result, vt[i].res);
      chk({vt[i].nm, "_valid"}, 32'(ex_mem_valid), 1);
      chk({vt[i].nm, "_rd"}, 32'(ex_mem_rd_addr), 32'(i + 1));
      chk({vt[i].nm, "_pc"}, ex_mem_pc, vt[i].pc);
    end

    // Flush in IDLE: bubble, no redirect
    apply(vt[19], 5'd3); flush = 1; #1;
    chk("flush_idle_taken", 32'(branch_taken), 0);
    @(posedge clk); #1;
    chk("flush_idle_valid", 32'(ex_mem_valid), 0);
    flush = 0;

    // mem_stall with no MD op: busy mirrors stall, EX/MEM holds
    apply(vt[0], 5'd1); id_ex_rs2_data = 32'd2; forward_a = 0; id_ex_rs1_data = 32'd1;
    @(posedge clk); #1;
    chk("stall_pre_res", ex_mem_result, 3);
    id_ex_rs1_data = 32'd10; id_ex_rs2_data = 32'd10; mem_stall = 1; #1;
    chk("stall_busy", 32'(ex_busy), 1);
    @(posedge clk); #1;
    chk("stall_hold", ex_mem_result, 3);
    mem_stall = 0; #1;
    chk("stall_busy_rel", 32'(ex_busy), 0);
    @(posedge clk); #1;
    chk("stall_rel_res", ex_mem_result, 20);
    id_ex_valid = 0;

    // M-ops
    run_md("mulh_neg",  F3_MULH,   32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 2);
    run_md("mul_lo",    F3_MUL,    32'h12345678, 32'h10,       32'h23456780, 2);
    run_md("mulhu",     F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2);
    run_md("mulhsu",    F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2);
    run_md("div_by0",   F3_DIV,    32'd7,        32'd0,        32'hFFFFFFFF, 33);
    run_md("rem_by0",   F3_REM,    32'd7,        32'd0,        32'd7,        33);
    run_md("div_ovf",   F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
    run_md("rem_ovf",   F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0,        33);
    run_md("div_neg",   F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_md("rem_neg",   F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_md("divu",      F3_DIVU,   32'd100,      32'd7,        32'd14,       33);
    run_md("remu",      F3_REMU,   32'd100,      32'd7,        32'd2,        33);

    // mem_stall while the multiply sits in DONE
    md_inputs(F3_MUL, 32'd3, 32'd5);
    @(posedge clk); #1;
    mem_stall = 1;
    @(posedge clk); #1;
    chk("md_stall_busy", 32'(ex_busy), 1);
    @(posedge clk); #1;
    chk("md_stall_novalid", 32'(ex_mem_valid), 0);
    chk("md_stall_busy2", 32'(ex_busy), 1);
    mem_stall = 0; #1;
    chk("md_stall_rel_busy", 32'(ex_busy), 0);
    @(posedge clk); #1;
    id_ex_valid = 0;
    chk("md_stall_valid", 32'(ex_mem_valid), 1);
    chk("md_stall_res", ex_mem_result, 15);

    // Flush during DIV cycle 10
    md_inputs(F3_DIVU, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1; flush = 1; #1;
    chk("flush_div_busy_hold", 32'(ex_busy), 1);
    @(posedge clk); #1;
    flush = 0; id_ex_valid = 0; #1;
    chk("flush_div_busy_drop", 32'(ex_busy), 0);
    chk("flush_div_valid", 32'(ex_mem_valid), 0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ex_mem_valid || ex_busy) seen = 1;
    end
    chk("flush_div_no_result", 32'(seen), 0);

    // Reset asserted mid-DIV
    md_inputs(F3_DIV, 32'd50, 32'd3); id_ex_pc = 32'h500; id_ex_rd_addr = 5'd7;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_pc", ex_mem_pc, 32'h500);
    reset = 1; #1;
    chk("rst_mid_valid", 32'(ex_mem_valid), 0);
    chk("rst_mid_result", ex_mem_result, 0);
    chk("rst_mid_pc", ex_mem_pc, 0);
    chk("rst_mid_rd", 32'(ex_mem_rd_addr), 0);
    chk("rst_mid_busy", 32'(ex_busy), 0);
    id_ex_valid = 0;
    @(posedge clk); #1; reset = 0;
    run_md("mul_after_rst", F3_MUL, 32'd6, 32'd7, 32'd42, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end
endmodule
